// File: rtl/cache_lru_pkg.sv
// Shared types and constants for the LRU tick table and its renormalisation FSM.
package cache_lru_pkg;

  localparam int unsigned TICK_WIDTH_DEF = 32;

  typedef logic [TICK_WIDTH_DEF-1:0] tick_t;

  typedef enum logic [0:0] {IDLE, RENORM} lru_state_t;

  localparam tick_t TICK_ZERO = '0;

  // Counter value after renormalisation: exactly half of the full range.
  function automatic tick_t renorm_start(input int unsigned width);
    tick_t t;
    t = TICK_ZERO;
    t[width-1] = 1'b1;
    return t;
  endfunction

  function automatic tick_t tick_max(input int unsigned width);
    return {TICK_WIDTH_DEF{1'b1}} >> (TICK_WIDTH_DEF - width);
  endfunction

endpackage

// File: rtl/lru_renorm_fsm.sv
// Global access counter plus the IDLE/RENORM sequencer that halves one set per cycle.
module lru_renorm_fsm
  import cache_lru_pkg::*;
#(
  parameter int SET_NUM    = 4,
  parameter int TICK_WIDTH = 32,
  localparam int SET_WIDTH = $clog2(SET_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acc_fire,
  output logic                  ready,
  output logic                  halve,
  output logic [SET_WIDTH-1:0]  ptr,
  output logic [TICK_WIDTH-1:0] now
);

  localparam tick_t MAX_FULL   = tick_max(TICK_WIDTH);
  localparam tick_t START_FULL = renorm_start(TICK_WIDTH);
  localparam logic [TICK_WIDTH-1:0] NOW_MAX   = MAX_FULL[TICK_WIDTH-1:0];
  localparam logic [TICK_WIDTH-1:0] NOW_START = START_FULL[TICK_WIDTH-1:0];
  localparam logic [SET_WIDTH-1:0]  PTR_LAST  = SET_WIDTH'(SET_NUM - 1);

  lru_state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      halve <= 1'b0;
      ptr   <= '0;
      now   <= TICK_WIDTH'(1);
    end else begin
      case (state)
        IDLE: begin
          if (acc_fire) begin
            // The saturating access is still stamped with NOW_MAX; the counter holds.
            if (now == NOW_MAX) begin
              state <= RENORM;
              ready <= 1'b0;
              halve <= 1'b1;
              ptr   <= '0;
            end else begin
              now <= now + 1'b1;
            end
          end
        end
        RENORM: begin
          if (ptr == PTR_LAST) begin
            state <= IDLE;
            ready <= 1'b1;
            halve <= 1'b0;
            ptr   <= '0;
            now   <= NOW_START;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          halve <= 1'b0;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lru_tick_table.sv
// Per-set, per-way last-access tick store for the LRU victim selector.
// Define LRU_BYPASS_EN to forward same-cycle writes onto the tick row.
module lru_tick_table
  import cache_lru_pkg::*;
#(
  parameter int SET_NUM    = 4,
  parameter int SET_SIZE   = 4,
  parameter int TICK_WIDTH = 32,
  localparam int SET_WIDTH = $clog2(SET_NUM),
  localparam int KEY_WIDTH = $clog2(SET_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_en,
  input  logic [SET_WIDTH-1:0] acc_set,
  input  logic [KEY_WIDTH-1:0] acc_way,
  input  logic                 inv_en,
  input  logic [SET_WIDTH-1:0] inv_set,
  input  logic [KEY_WIDTH-1:0] inv_way,
  input  logic [SET_WIDTH-1:0] rd_set,
  output tick_t [SET_SIZE-1:0] tick,
  output logic                 ready
);

  logic                  halve;
  logic [SET_WIDTH-1:0]  ptr;
  logic [TICK_WIDTH-1:0] now;
  logic                  acc_fire;
  logic                  inv_fire;

  logic [TICK_WIDTH-1:0] tbl [SET_NUM][SET_SIZE];

  assign acc_fire = acc_en && ready;
  assign inv_fire = inv_en && ready;

  lru_renorm_fsm #(
    .SET_NUM    (SET_NUM),
    .TICK_WIDTH (TICK_WIDTH)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .acc_fire (acc_fire),
    .ready    (ready),
    .halve    (halve),
    .ptr      (ptr),
    .now      (now)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SET_NUM; s++) begin
        for (int w = 0; w < SET_SIZE; w++) begin
          tbl[s][w] <= '0;
        end
      end
    end else if (halve) begin
      for (int w = 0; w < SET_SIZE; w++) begin
        tbl[ptr][w] <= tbl[ptr][w] >> 1;
      end
    end else begin
      // Access is written last so it wins over an invalidate of the same line.
      if (inv_fire) tbl[inv_set][inv_way] <= '0;
      if (acc_fire) tbl[acc_set][acc_way] <= now;
    end
  end

  always_comb begin
    for (int w = 0; w < SET_SIZE; w++) begin
      tick[w] = tick_t'(tbl[rd_set][w]);
`ifdef LRU_BYPASS_EN
      if (inv_fire && rd_set == inv_set && inv_way == KEY_WIDTH'(w)) tick[w] = TICK_ZERO;
      if (acc_fire && rd_set == acc_set && acc_way == KEY_WIDTH'(w)) tick[w] = tick_t'(now);
`endif
    end
  end

endmodule

// File: tb/tb_lru_tick_table.sv
// Directed scoreboard bench for lru_tick_table with a shrunk tick width to force renormalisation.
module tb_lru_tick_table;
  import cache_lru_pkg::*;

  localparam int SET_NUM    = 2;
  localparam int SET_SIZE   = 4;
  localparam int TICK_WIDTH = 4;
  localparam int SET_WIDTH  = $clog2(SET_NUM);
  localparam int KEY_WIDTH  = $clog2(SET_SIZE);

  logic                 clk;
  logic                 reset;
  logic                 acc_en;
  logic [SET_WIDTH-1:0] acc_set;
  logic [KEY_WIDTH-1:0] acc_way;
  logic                 inv_en;
  logic [SET_WIDTH-1:0] inv_set;
  logic [KEY_WIDTH-1:0] inv_way;
  logic [SET_WIDTH-1:0] rd_set;
  tick_t [SET_SIZE-1:0] tick;
  logic                 ready;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  lru_tick_table #(
    .SET_NUM    (SET_NUM),
    .SET_SIZE   (SET_SIZE),
    .TICK_WIDTH (TICK_WIDTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .acc_en  (acc_en),
    .acc_set (acc_set),
    .acc_way (acc_way),
    .inv_en  (inv_en),
    .inv_set (inv_set),
    .inv_way (inv_way),
    .rd_set  (rd_set),
    .tick    (tick),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] val);
    sb_item_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_row(input string tag, input logic [SET_WIDTH-1:0] s,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    rd_set = s;
    #1;
    push($sformatf("%s_w0", tag), e0);
    push($sformatf("%s_w1", tag), e1);
    push($sformatf("%s_w2", tag), e2);
    push($sformatf("%s_w3", tag), e3);
    for (int w = 0; w < SET_SIZE; w++) check(tick[w]);
  endtask

  // Reference selector: minimum tick, ties to the lower way.
  function automatic logic [31:0] lru_pick(input tick_t [SET_SIZE-1:0] t);
    logic [31:0] best;
    best = 0;
    for (int w = 1; w < SET_SIZE; w++) if (t[w] < t[best]) best = w;
    return best;
  endfunction

  task automatic access(input int s, input int w);
    acc_en  = 1'b1;
    acc_set = SET_WIDTH'(s);
    acc_way = KEY_WIDTH'(w);
    @(posedge clk);
    #1;
    acc_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    acc_en = 1'b0; acc_set = '0; acc_way = '0;
    inv_en = 1'b0; inv_set = '0; inv_way = '0;
    rd_set = '0;
    #13 reset = 1'b0;
    @(posedge clk);
    #1;

    push("reset_ready", 1); check(ready);
    check_row("reset_set0", 0, 0, 0, 0, 0);
    check_row("reset_set1", 1, 0, 0, 0, 0);

    access(0, 2);
    access(0, 0);
    access(0, 3);
    check_row("basic", 0, 2, 0, 1, 3);
    push("lru_pick", 1); check(lru_pick(tick));

    // Invalidate and access to different ways in one cycle.
    inv_en = 1'b1; inv_set = 0; inv_way = 3;
    access(0, 1);
    inv_en = 1'b0;
    check_row("acc_inv", 0, 2, 4, 1, 0);

    // Same target: access wins.
    inv_en = 1'b1; inv_set = 0; inv_way = 1;
    access(0, 1);
    inv_en = 1'b0;
    check_row("same_tgt", 0, 2, 5, 1, 0);

    for (int i = 6; i <= 12; i++) access(0, 2);
    access(1, 2);
    access(1, 3);
    check_row("pre_renorm", 1, 0, 0, 13, 14);

    // now == 15: this access triggers renormalisation.
    access(1, 0);
    acc_en = 1'b1; acc_set = 0; acc_way = 1;
    push("renorm_c1_ready", 0); check(ready);
    @(posedge clk); #1;
    push("renorm_c2_ready", 0); check(ready);
    @(posedge clk); #1;
    push("renorm_done_ready", 1); check(ready);
    check_row("held_not_applied", 0, 1, 2, 6, 0);
    @(posedge clk); #1;
    acc_en = 1'b0;
    check_row("post_renorm_set0", 0, 1, 8, 6, 0);
    check_row("post_renorm_set1", 1, 7, 0, 6, 7);

    // Second wrap, then reset in the second RENORM cycle.
    for (int i = 9; i <= 14; i++) access(1, 1);
    check_row("pre_wrap2", 1, 7, 14, 6, 7);
    access(1, 3);
    push("wrap2_ready", 0); check(ready);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    push("mid_reset_ready", 1); check(ready);
    rd_set = 0;
    #1;
    for (int w = 0; w < SET_SIZE; w++) begin
      push($sformatf("mid_reset_set0_w%0d", w), 0); check(tick[w]);
    end
    rd_set = 1;
    #1;
    for (int w = 0; w < SET_SIZE; w++) begin
      push($sformatf("mid_reset_set1_w%0d", w), 0); check(tick[w]);
    end
    reset = 1'b0;

    // Post-reset access with same-cycle visibility check.
    acc_en = 1'b1; acc_set = 1; acc_way = 2; rd_set = 1;
    #1;
`ifdef LRU_BYPASS_EN
    push("bypass_same_cycle", 1);
`else
    push("no_bypass_same_cycle", 0);
`endif
    check(tick[2]);
    @(posedge clk); #1;
    acc_en = 1'b0;
    push("stamp_after_reset", 1); check(tick[2]);
    access(1, 0);
    push("stamp_next", 2); check(tick[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lru_tick_table.md
Name: lru_tick_table

Overview:
- Per-set, per-way last-access timestamp store feeding the LRU victim selector.
- Keeps a global access counter and stamps a line with it on each hit or fill.
- Presents the 32-bit tick row of the looked-up set; the least-recently-used way has the minimum tick.
- On counter exhaustion, a multi-cycle renormalisation pass halves every stored tick, so relative order never corrupts.

Parameters:
- SET_NUM, `CACHE_S (cache.vh): number of sets; power of two, ≥2.
- SET_SIZE, `CACHE_E (cache.vh): ways per set; matches victim selector.
- TICK_WIDTH, 32: stored tick width, 2..32; benches shrink it to force wrap.
- SET_WIDTH, $clog2(SET_NUM): set index width (derived).
- KEY_WIDTH, $clog2(SET_SIZE): way index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- acc_en  in  1  access (hit or fill) request
- acc_set  in  SET_WIDTH  set being accessed
- acc_way  in  KEY_WIDTH  way being accessed
- inv_en  in  1  invalidate-line request
- inv_set  in  SET_WIDTH  set to invalidate
- inv_way  in  KEY_WIDTH  way to invalidate
- rd_set  in  SET_WIDTH  set whose ticks are presented
- tick  out  32 x SET_SIZE  tick row of rd_set, zero-extended from TICK_WIDTH
- ready  out  1  high when requests are accepted (state IDLE)

Behaviour:
- Reset (asynchronous, active-high): all table entries 0; now = 1; state IDLE; ready = 1; renorm pointer 0.
- Tick 0 means never used or invalid, so such a way is always chosen first.
- tick output is combinational from the table. It reflects writes from earlier cycles; a same-cycle write is not visible unless LRU_BYPASS_EN is defined.
- States:
  - IDLE: ready = 1.
  - RENORM: ready = 0; ptr walks 0..SET_NUM-1.
- Accepted access (acc_en && ready): table[acc_set][acc_way] <= now at the next edge.
  - If now != 2^TICK_WIDTH-1: now <= now+1.
  - If now == 2^TICK_WIDTH-1: now is held, state <= RENORM, ptr <= 0.
- Accepted invalidate (inv_en && ready): table[inv_set][inv_way] <= 0.
  - If acc and inv target the same set and way in one cycle, the access wins.
  - Different targets are both applied.
- acc_en or inv_en while ready = 0: ignored, no side effects. The requester must hold the request until ready.
- RENORM, one set per cycle: every way of table[ptr] <= table[ptr] >> 1; ptr <= ptr+1.
  - On ptr == SET_NUM-1: now <= 2^(TICK_WIDTH-1), state <= IDLE.
  - Duration is exactly SET_NUM cycles.
- Renormalisation invariants:
  - Afterwards every stored tick is < now.
  - Order is non-strict: adjacent ticks may tie. Ties resolve in the selector to the lower way index.
  - A zero tick stays zero.
- rd_set during RENORM: shows the partially halved table. The consumer must not act on it while ready = 0.
- Reset mid-RENORM: table cleared, IDLE, now = 1.
- Width: all tick arithmetic is TICK_WIDTH bits unsigned; no wrap past 2^TICK_WIDTH-1 ever occurs.

Optional Feature:
- Macro: LRU_BYPASS_EN.
- Defined: when acc_en && ready && rd_set == acc_set, tick[acc_way] shows now in the same cycle. The same applies to a colliding invalidate, which shows 0; the access still wins on equal targets.
- Not defined: no forwarding; tick shows the registered table only, and the write becomes visible the cycle after.

Decomposition:
- Package cache_lru_pkg holds:
  - tick_t (logic [TICK_WIDTH-1:0], default width 32)
  - lru_state_t enum {IDLE, RENORM}
  - TICK_ZERO constant
  - a renorm-start localparam helper
- Sub-module lru_renorm_fsm owns:
  - state, ptr and now
  - the ready, row-halve strobe and row pointer outputs
- The top module owns the table and the write/forward mux.

Test Plan:
- Reset, then accesses (set0, way2), (set0, way0), (set0, way3) on consecutive cycles; read rd_set=0 → tick = {2, 0, 1, 3}; the selector picks way1 (tick 0).
- Invalidate (set0, way3) together with access (set0, way1) → next cycle tick = {2, 4, 1, 0}. Then same-target acc+inv on (set0, way1) → way1 = 5, not 0.
- TICK_WIDTH=4, SET_NUM=2: drive accesses until now = 15, then access (set1, way0) → ready low for exactly 2 cycles; set1 way0 = 7, a prior tick 14 becomes 7, 13 becomes 6; afterwards now = 8 and the next access writes 8.
- During RENORM hold acc_en on (set0, way1) → not applied until ready returns; then written with 8; no other entry changes.
- Assert reset in the second RENORM cycle → all ticks 0, ready = 1, the next access stamps 1.
- With LRU_BYPASS_EN: access (set1, way2) with rd_set = 1 → tick[2] equals now in the same cycle. Without it → old value that cycle, new value the next.
